segasys1_sndlatch: RTL and testbench
====================================

Name: segasys1_sndlatch

Overview:
Sound-board end of the main-to-sound command path. It receives the main CPU's sound request (SNDRQ strobe plus SNDNO byte), queues commands in a small FIFO, and raises an NMI request to the sound CPU. It presents the head command on the sound CPU's latch read address, pops on read completion, and generates the sound CPU's periodic timer IRQ.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries)
NMI_GAP, 16, minimum CLK40M cycles SNMI stays low between consecutive NMI requests
IRQ_PERIOD, 166667, CLK40M cycles between timer IRQs (4 per 60 Hz frame)
IRQ_WIDTH, 512, maximum CLK40M cycles SIRQ stays high when not acknowledged

Ports:
CLK40M  in  1  system clock; only clock in the block
RESET  in  1  asynchronous, active-high reset
SNDRQ  in  1  sound request from main CPU; may stay high several cycles per write
SNDNO  in  8  sound command byte; valid while SNDRQ high
SCPUAD  in  16  sound CPU address
SCPU_MREQ  in  1  sound CPU memory request, active high
SCPU_IORQ  in  1  sound CPU IO request, active high
SCPU_RD  in  1  sound CPU read strobe, active high
SCPU_M1  in  1  sound CPU M1, active high
LATCS  out  1  latch selected: SCPUAD[15:12]==4'hE & SCPU_MREQ (combinational)
LATDO  out  8  command byte returned to sound CPU
SNMI  out  1  NMI request to sound CPU, active high
SIRQ  out  1  timer IRQ request to sound CPU, active high
PENDING  out  DEPTH_LOG2+1  FIFO occupancy
OVF  out  1  sticky overflow flag

Behaviour:
- Reset (async): FIFO empty, PENDING=0, LATDO=8'h00, SNMI=0, SIRQ=0, OVF=0, gap counter 0, IRQ counter 0, all edge-detect registers 0.
- Push: on the rising edge of SNDRQ (SNDRQ=1, previous-cycle SNDRQ=0), write SNDNO from that cycle. Exactly one push per SNDRQ high period, whatever its length.
- Push while full: byte dropped, FIFO unchanged, OVF set to 1 and held until RESET.
- Read: rd_act = LATCS & SCPU_RD. Pop occurs on the falling edge of rd_act, i.e. the first cycle rd_act=0 after having been 1.
- LATDO is a register. While the FIFO is non-empty it shows the head entry. On a pop it keeps the popped value until a new head exists. Reading an empty FIFO returns the last value and pops nothing.
- LATDO never changes while rd_act=1, except that a push into an empty FIFO updates LATDO on the next cycle.
- Push and pop in the same cycle: both take effect and PENDING is unchanged. If full, the pop frees the slot and the push is accepted (no OVF).
- Pointers wrap modulo 2^DEPTH_LOG2. PENDING runs 0..2^DEPTH_LOG2.
- NMI state machine:
  - IDLE: SNMI=0. Go to ASSERT when PENDING>0 and the gap counter is 0.
  - ASSERT: SNMI=1. On a pop, go to GAP and load the gap counter with NMI_GAP.
  - GAP: SNMI=0. Counter decrements once per cycle. At 0, return to IDLE.
  - Result: every queued command produces a distinct NMI rising edge.
- IRQ timer:
  - Free-running counter 0..IRQ_PERIOD-1 that wraps to 0. SIRQ is set on the cycle the counter wraps.
  - SIRQ clears on acknowledge (SCPU_M1 & SCPU_IORQ) or after IRQ_WIDTH cycles high, whichever comes first.
  - A wrap on the same cycle as an acknowledge re-sets SIRQ; set wins.
- Reset mid-operation: all state returns to reset values immediately; queued commands are lost.

Test Plan:
- Reset, then SNDRQ high 5 cycles with SNDNO=8'h23 -> PENDING=1, LATDO=8'h23, SNMI rises within 2 cycles; exactly one entry queued.
- Sound CPU reads $E000 (rd_act high 4 cycles) -> LATDO=8'h23 throughout. Pop after the strobe: PENDING=0, SNMI low, and SNMI stays low for all of that time.
- Push 8'h01, 8'h02, 8'h03 back to back, then three reads -> reads return 01, 02, 03 in order. SNMI drops for at least 16 cycles between NMIs, giving 3 separate rising edges.
- Push 5 commands 8'hA0..8'hA4 with no reads -> PENDING=4, OVF=1, A4 dropped. Reads return A0..A3, then a 5th read returns A3 with PENDING=0.
- Full FIFO with pop-falling-edge and SNDRQ rising edge in the same cycle -> PENDING stays 4, OVF stays 0, new byte read last.
- Run 2*IRQ_PERIOD cycles with no acknowledge -> SIRQ high twice, 512 cycles each. A repeat run with acknowledge 10 cycles after SIRQ rises -> SIRQ high exactly 10 cycles.

Source files
------------

// File: rtl/segasys1_sndlatch_if.sv
// Main-to-sound command path bundle: main CPU request side,
// sound CPU bus side, and latch status outputs.
interface segasys1_sndlatch_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic                SNDRQ;
  logic [7:0]          SNDNO;
  logic [15:0]         SCPUAD;
  logic                SCPU_MREQ;
  logic                SCPU_IORQ;
  logic                SCPU_RD;
  logic                SCPU_M1;
  logic                LATCS;
  logic [7:0]          LATDO;
  logic                SNMI;
  logic                SIRQ;
  logic [DEPTH_LOG2:0] PENDING;
  logic                OVF;

  modport master (
    output SNDRQ, SNDNO, SCPUAD,
    output SCPU_MREQ, SCPU_IORQ,
    output SCPU_RD, SCPU_M1,
    input  LATCS, LATDO, SNMI,
    input  SIRQ, PENDING, OVF
  );

  modport slave (
    input  SNDRQ, SNDNO, SCPUAD,
    input  SCPU_MREQ, SCPU_IORQ,
    input  SCPU_RD, SCPU_M1,
    output LATCS, LATDO, SNMI,
    output SIRQ, PENDING, OVF
  );
endinterface

// File: rtl/segasys1_sndlatch.sv
// Sound-board command latch: FIFO of main CPU sound requests,
// NMI per queued command, and periodic timer IRQ.
module segasys1_sndlatch #(
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_GAP    = 16,
  parameter int IRQ_PERIOD = 166667,
  parameter int IRQ_WIDTH  = 512
) (
  input logic CLK40M,
  input logic RESET,
  segasys1_sndlatch_if.slave bus
);
  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int GW    = $clog2(NMI_GAP + 1);
  localparam int CW    = $clog2(IRQ_PERIOD + 1);
  localparam int WW    = $clog2(IRQ_WIDTH + 1);
  localparam logic [CW-1:0] TOP  = CW'(IRQ_PERIOD - 1);
  localparam logic [WW-1:0] WMAX = WW'(IRQ_WIDTH);
  localparam logic [GW-1:0] GLD  = GW'(NMI_GAP);

  typedef enum logic [1:0] {
    N_IDLE, N_ASSERT, N_GAP
  } nmi_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, cnt_nxt;
  logic [7:0]    latdo_q, head_nxt;
  logic          sndrq_q, rd_q, rd_act;
  logic          push, pop, push_ok;
  logic          empty, full, ovf_q;
  nmi_t          st, st_n;
  logic [GW-1:0] gap, gap_n;
  logic [CW-1:0] tcnt;
  logic [WW-1:0] wcnt;
  logic          sirq_q, wrap, ack;
  logic          addr_unused;

  assign addr_unused = ^bus.SCPUAD[11:0];

  assign bus.LATCS = (bus.SCPUAD[15:12] == 4'hE)
                   & bus.SCPU_MREQ;
  assign rd_act  = bus.LATCS & bus.SCPU_RD;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = bus.SNDRQ & ~sndrq_q;
  assign pop     = rd_q & ~rd_act & ~empty;
  assign push_ok = push & (~full | pop);

  // LATDO tracks the head as it will be after this edge
  always_comb begin
    cnt_nxt  = count + (AW+1)'(push_ok)
             - (AW+1)'(pop);
    rd_nxt   = pop ? rd_ptr + AW'(1) : rd_ptr;
    head_nxt = latdo_q;
    if (cnt_nxt != '0) begin
      if (push_ok && wr_ptr == rd_nxt)
        head_nxt = bus.SNDNO;
      else
        head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge CLK40M) begin
    if (push_ok) mem[wr_ptr] <= bus.SNDNO;
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      latdo_q <= 8'h00;
      sndrq_q <= 1'b0;
      rd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sndrq_q <= bus.SNDRQ;
      rd_q    <= rd_act;
      count   <= cnt_nxt;
      rd_ptr  <= rd_nxt;
      latdo_q <= head_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    st_n  = st;
    gap_n = gap;
    unique case (st)
      N_IDLE:
        if (!empty && gap == '0) st_n = N_ASSERT;
      N_ASSERT:
        if (pop) begin
          st_n  = N_GAP;
          gap_n = GLD;
        end
      N_GAP:
        if (gap == '0) st_n = N_IDLE;
        else gap_n = gap - GW'(1);
      default: st_n = N_IDLE;
    endcase
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      st  <= N_IDLE;
      gap <= '0;
    end else begin
      st  <= st_n;
      gap <= gap_n;
    end
  end

  assign wrap = (tcnt == TOP);
  assign ack  = bus.SCPU_M1 & bus.SCPU_IORQ;

  // a wrap re-arms SIRQ even when an acknowledge lands
  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      tcnt   <= '0;
      wcnt   <= '0;
      sirq_q <= 1'b0;
    end else begin
      tcnt <= wrap ? '0 : tcnt + CW'(1);
      if (wrap) begin
        sirq_q <= 1'b1;
        wcnt   <= WW'(1);
      end else if (sirq_q) begin
        if (ack || wcnt == WMAX) sirq_q <= 1'b0;
        else wcnt <= wcnt + WW'(1);
      end
    end
  end

  assign bus.LATDO   = latdo_q;
  assign bus.PENDING = count;
  assign bus.OVF     = ovf_q;
  assign bus.SNMI    = (st == N_ASSERT);
  assign bus.SIRQ    = sirq_q;
endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Directed bench for segasys1_sndlatch: FIFO order, overflow,
// NMI spacing and timer IRQ width/acknowledge.
module tb_segasys1_sndlatch;
  localparam int PER = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  segasys1_sndlatch_if #(.DEPTH_LOG2(2)) bus ();

  segasys1_sndlatch #(
    .DEPTH_LOG2(2),
    .NMI_GAP(16),
    .IRQ_PERIOD(PER),
    .IRQ_WIDTH(512)
  ) dut (
    .CLK40M(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   nmi_rises = 0;
  int   low_run = 0;
  int   min_low = 1000;
  logic snmi_prev = 1'b0;
  bit   seen_fall = 1'b0;

  always @(negedge clk) begin
    if (bus.SNMI && !snmi_prev) begin
      nmi_rises++;
      if (seen_fall && low_run < min_low)
        min_low = low_run;
    end
    if (bus.SNMI) low_run = 0;
    else low_run++;
    if (!bus.SNMI && snmi_prev) seen_fall = 1'b1;
    snmi_prev = bus.SNMI;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.SNDRQ = 1'b1;
    bus.SNDNO = b;
    step(1);
    bus.SNDRQ = 1'b0;
    step(1);
  endtask

  task automatic wait_nmi();
    for (int i = 0; i < 60 && !bus.SNMI; i++)
      step(1);
    chk("nmi_wait", 32'(bus.SNMI), 1);
  endtask

  task automatic do_read(input bit wn,
                         output logic [7:0] v,
                         output bit stable);
    if (wn) wait_nmi();
    bus.SCPUAD    = 16'hE000;
    bus.SCPU_MREQ = 1'b1;
    bus.SCPU_RD   = 1'b1;
    v = bus.LATDO;
    stable = 1'b1;
    repeat (4) begin
      step(1);
      if (bus.LATDO !== v) stable = 1'b0;
    end
    bus.SCPU_MREQ = 1'b0;
    bus.SCPU_RD   = 1'b0;
    step(1);
  endtask

  task automatic wait_sirq(input int lim,
                           output int n);
    logic p;
    p = bus.SIRQ;
    n = 0;
    while (n < lim) begin
      step(1);
      n++;
      if (bus.SIRQ && !p) break;
      p = bus.SIRQ;
    end
    chk("sirq_rise_wait", 32'(bus.SIRQ), 1);
  endtask

  task automatic count_high(input int ack_at,
                            output int hi);
    hi = 1;
    while (bus.SIRQ && hi < 1000) begin
      if (hi == ack_at) begin
        bus.SCPU_M1   = 1'b1;
        bus.SCPU_IORQ = 1'b1;
      end
      step(1);
      bus.SCPU_M1   = 1'b0;
      bus.SCPU_IORQ = 1'b0;
      if (bus.SIRQ) hi++;
    end
  endtask

  initial begin
    logic [7:0] v;
    bit   st;
    int   r0, n, hi;
    logic [7:0] exp3 [3];
    logic [7:0] expa [4];
    logic [7:0] expb [4];

    bus.SNDRQ = 0; bus.SNDNO = 0;
    bus.SCPUAD = 0; bus.SCPU_MREQ = 0;
    bus.SCPU_IORQ = 0; bus.SCPU_RD = 0;
    bus.SCPU_M1 = 0;
    step(2);
    chk("rst_pending", 32'(bus.PENDING), 0);
    chk("rst_latdo", 32'(bus.LATDO), 0);
    chk("rst_snmi", 32'(bus.SNMI), 0);
    chk("rst_sirq", 32'(bus.SIRQ), 0);
    chk("rst_ovf", 32'(bus.OVF), 0);
    rst = 1'b0;
    step(2);

    bus.SCPUAD = 16'hE000;
    bus.SCPU_MREQ = 1'b1;
    #1;
    chk("latcs_hit", 32'(bus.LATCS), 1);
    bus.SCPUAD = 16'hD000;
    #1;
    chk("latcs_miss", 32'(bus.LATCS), 0);
    bus.SCPU_MREQ = 1'b0;

    bus.SNDRQ = 1'b1;
    bus.SNDNO = 8'h23;
    step(1);
    chk("t1_pending", 32'(bus.PENDING), 1);
    chk("t1_latdo", 32'(bus.LATDO), 32'h23);
    step(1);
    chk("t1_snmi", 32'(bus.SNMI), 1);
    step(3);
    bus.SNDRQ = 1'b0;
    step(1);
    chk("t1_one_entry", 32'(bus.PENDING), 1);

    do_read(1'b1, v, st);
    chk("t2_data", 32'(v), 32'h23);
    chk("t2_stable", 32'(st), 1);
    chk("t2_pending", 32'(bus.PENDING), 0);
    chk("t2_latdo_hold", 32'(bus.LATDO), 32'h23);
    st = 1'b1;
    repeat (40) begin
      if (bus.SNMI) st = 1'b0;
      step(1);
    end
    chk("t2_snmi_low", 32'(st), 1);

    r0 = nmi_rises;
    exp3 = '{8'h01, 8'h02, 8'h03};
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("t3_pending", 32'(bus.PENDING), 3);
    for (int i = 0; i < 3; i++) begin
      do_read(1'b1, v, st);
      chk("t3_data", 32'(v), 32'(exp3[i]));
    end
    step(2);
    chk("t3_nmi_edges", 32'(nmi_rises - r0), 3);
    chk("t3_gap_ge16", 32'(min_low >= 16), 1);
    step(30);

    expa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 5; i++)
      push(8'hA0 + 8'(i));
    chk("t4_pending", 32'(bus.PENDING), 4);
    chk("t4_ovf", 32'(bus.OVF), 1);
    for (int i = 0; i < 4; i++) begin
      do_read(1'b1, v, st);
      chk("t4_data", 32'(v), 32'(expa[i]));
    end
    do_read(1'b0, v, st);
    chk("t4_empty_read", 32'(v), 32'hA3);
    chk("t4_empty_pend", 32'(bus.PENDING), 0);
    chk("t4_ovf_sticky", 32'(bus.OVF), 1);

    push(8'hC5);
    rst = 1'b1;
    #1;
    chk("rst_mid_pend", 32'(bus.PENDING), 0);
    chk("rst_mid_ovf", 32'(bus.OVF), 0);
    step(1);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 4; i++)
      push(8'hB0 + 8'(i));
    chk("t5_full", 32'(bus.PENDING), 4);
    wait_nmi();
    bus.SCPUAD    = 16'hE000;
    bus.SCPU_MREQ = 1'b1;
    bus.SCPU_RD   = 1'b1;
    v = bus.LATDO;
    step(2);
    bus.SCPU_MREQ = 1'b0;
    bus.SCPU_RD   = 1'b0;
    bus.SNDRQ = 1'b1;
    bus.SNDNO = 8'hB4;
    step(1);
    bus.SNDRQ = 1'b0;
    chk("t5_first", 32'(v), 32'hB0);
    chk("t5_pending", 32'(bus.PENDING), 4);
    chk("t5_ovf", 32'(bus.OVF), 0);
    step(1);
    expb = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 4; i++) begin
      do_read(1'b1, v, st);
      chk("t5_data", 32'(v), 32'(expb[i]));
    end
    chk("t5_drained", 32'(bus.PENDING), 0);

    wait_sirq(2 * PER + 10, n);
    count_high(0, hi);
    chk("t6_width1", 32'(hi), 512);
    wait_sirq(2 * PER + 10, n);
    chk("t6_period", 32'(hi + n), 32'(PER));
    count_high(0, hi);
    chk("t6_width2", 32'(hi), 512);
    wait_sirq(2 * PER + 10, n);
    count_high(10, hi);
    chk("t6_ack_width", 32'(hi), 10);
    chk("t6_ack_low", 32'(bus.SIRQ), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
